// File: rtl/up_counter_sched_ctrl_if.sv
// Control/status bundle between the sequencing logic (master) and the counter controller (slave).
// Commands plus a terminal value go in; the count value and status flags come back.
interface up_counter_sched_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       state;

  modport master (
    output start, stop, pause, mode, load_val,
    input  count, busy, done, err, state
  );

  modport slave (
    input  start, stop, pause, mode, load_val,
    output count, busy, done, err, state
  );
endinterface

// File: rtl/up_counter_sched_ctrl.sv
// Up-counter sequencer: runs 0..T once or periodically. All outputs are registered, and count=n at edge k+n after a start at edge k.
// There is no backpressure; pause is the only way to hold the count, and stop takes priority over start, which takes priority over pause.
module up_counter_sched_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  up_counter_sched_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  logic [1:0]       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] t_reg;
  logic             mode_reg;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] count_inc;
  logic             load_ok;

  assign count_inc = count + WIDTH'(1);
  assign load_ok   = (bus.load_val != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      t_reg    <= '0;
      mode_reg <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.stop) begin
            state <= IDLE;
            count <= '0;
          end else if (bus.start) begin
            if (load_ok) begin
              t_reg    <= bus.load_val;
              mode_reg <= bus.mode;
              count    <= '0;
              state    <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state <= IDLE;
            count <= '0;
          end else if (!bus.start && bus.pause) begin
            state <= PAUSE;
          end else begin
            // An illegal start is flagged but does not disturb the running count.
            if (bus.start) err <= 1'b1;
            if (count != t_reg) begin
              count <= count_inc;
              if (count_inc == t_reg) done <= 1'b1;
            end else if (mode_reg) begin
              count <= '0;
            end else begin
              state <= DONE;
            end
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state <= IDLE;
            count <= '0;
          end else if (bus.start) begin
            err <= 1'b1;
          end else if (!bus.pause) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.count = count;
  assign bus.state = state;
  assign bus.busy  = (state == RUN) || (state == PAUSE);
  assign bus.done  = done;
  assign bus.err   = err;

endmodule

// File: tb/tb_up_counter_sched_ctrl.sv
// Directed bench for up_counter_sched_ctrl: reset, one-shot, periodic, pause, err and stop cases.
module tb_up_counter_sched_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   done_seen;

  up_counter_sched_ctrl_if #(.WIDTH(4)) bus ();

  up_counter_sched_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.mode     = 1'b0;
    bus.load_val = 4'd0;
    #12;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_busy",  32'(bus.busy),  0);
    chk("rst_done",  32'(bus.done),  0);
    chk("rst_err",   32'(bus.err),   0);
    rst = 1'b0;
    tick();

    // One-shot, T=5
    bus.mode = 1'b0; bus.load_val = 4'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("os5_cnt0",  32'(bus.count), 0);
    chk("os5_run",   32'(bus.state), 1);
    chk("os5_busy",  32'(bus.busy),  1);
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("os5_cnt",  32'(bus.count), 32'(n));
      chk("os5_done", 32'(bus.done),  32'(n == 5));
    end
    tick();
    chk("os5_state_done", 32'(bus.state), 3);
    chk("os5_hold",       32'(bus.count), 5);
    chk("os5_busy0",      32'(bus.busy),  0);
    chk("os5_done_clr",   32'(bus.done),  0);
    tick();
    chk("os5_hold2",      32'(bus.count), 5);
    chk("os5_state2",     32'(bus.state), 3);

    // Async reset in the middle of a run
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("mid_cnt3", 32'(bus.count), 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_state", 32'(bus.state), 0);
    chk("arst_busy",  32'(bus.busy),  0);
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_state", 32'(bus.state), 0);
    chk("post_rst_count", 32'(bus.count), 0);

    // Periodic, T=3
    bus.mode = 1'b1; bus.load_val = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("per3_cnt0", 32'(bus.count), 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("per3_cnt",   32'(bus.count), 32'(i % 4));
      chk("per3_done",  32'(bus.done),  32'((i % 4) == 3));
      chk("per3_state", 32'(bus.state), 1);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("per3_stop_cnt",   32'(bus.count), 0);
    chk("per3_stop_state", 32'(bus.state), 0);
    chk("per3_stop_busy",  32'(bus.busy),  0);

    // One-shot T=6 with pause held for 3 edges at count 2
    done_seen = 0;
    bus.mode = 1'b0; bus.load_val = 4'd6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    chk("p6_cnt2", 32'(bus.count), 2);
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p6_hold",  32'(bus.count), 2);
      chk("p6_state", 32'(bus.state), 2);
      chk("p6_busy",  32'(bus.busy),  1);
      done_seen += int'(bus.done);
    end
    bus.pause = 1'b0;
    tick();
    chk("p6_resume_cnt",   32'(bus.count), 2);
    chk("p6_resume_state", 32'(bus.state), 1);
    done_seen += int'(bus.done);
    for (int n = 3; n <= 6; n++) begin
      tick();
      chk("p6_cnt", 32'(bus.count), 32'(n));
      done_seen += int'(bus.done);
    end
    tick();
    done_seen += int'(bus.done);
    chk("p6_done_once", 32'(done_seen), 1);
    chk("p6_final",     32'(bus.state), 3);
    chk("p6_final_cnt", 32'(bus.count), 6);

    // Illegal starts
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("e_idle", 32'(bus.state), 0);
    bus.load_val = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("e_zero_err",   32'(bus.err),   1);
    chk("e_zero_state", 32'(bus.state), 0);
    tick();
    chk("e_zero_clr",   32'(bus.err),   0);
    bus.mode = 1'b0; bus.load_val = 4'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("e_run_cnt1", 32'(bus.count), 1);
    bus.load_val = 4'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("e_run_err",   32'(bus.err),   1);
    chk("e_run_cnt",   32'(bus.count), 2);
    chk("e_run_state", 32'(bus.state), 1);
    tick();
    chk("e_run_clr",  32'(bus.err),   0);
    chk("e_run_cnt3", 32'(bus.count), 3);

    // stop + start together: stop wins, no err
    bus.stop = 1'b1; bus.start = 1'b1; bus.load_val = 4'd7;
    tick();
    bus.stop = 1'b0; bus.start = 1'b0;
    chk("ss_state", 32'(bus.state), 0);
    chk("ss_count", 32'(bus.count), 0);
    chk("ss_err",   32'(bus.err),   0);

    // Periodic at full range, T=15
    bus.mode = 1'b1; bus.load_val = 4'd15; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("p15_cnt0", 32'(bus.count), 0);
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("p15_cnt",  32'(bus.count), 32'(i % 16));
      chk("p15_done", 32'(bus.done),  32'((i % 16) == 15));
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("p15_stop", 32'(bus.state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
